// File: rtl/fetch_branch_predictor.sv
// Fetch PC generator with direct-mapped BTB and 2-bit saturating BHT; lookup is zero-latency from pc_o.
// Optional macro BP_STATS_EN adds branch/misprediction counters (br_cnt_o, mispred_cnt_o).
module fetch_branch_predictor #(
    parameter int          INDEX_W  = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_upd_vld,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    output logic [31:0] pc_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_pc_o
`ifdef BP_STATS_EN
    ,
    output logic [31:0] br_cnt_o,
    output logic [31:0] mispred_cnt_o
`endif
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = 30 - INDEX_W;

    logic [31:0]        pc_q;
    logic [31:0]        pc_d;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [1:0]         bht_q [ENTRIES];

    // Lookup side
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic [31:0]        seq_pc;

    // Update side
    logic [INDEX_W-1:0] uidx;
    logic [TAG_W-1:0]   utag;
    logic               uhit;
    logic               upd_we;
    logic [1:0]         bht_wr_d;
    logic [31:0]        tgt_wr_d;

    logic               unused_upd_lsb;
    assign unused_upd_lsb = &{1'b0, i_upd_pc[1:0]};

    assign idx    = pc_q[INDEX_W+1:2];
    assign tag    = pc_q[31:INDEX_W+2];
    assign hit    = valid_q[idx] && (tag_q[idx] == tag);
    assign seq_pc = pc_q + 32'd4;

    always_comb begin
        pred_taken_o = hit && bht_q[idx][1];
        pred_pc_o    = pred_taken_o ? tgt_q[idx] : seq_pc;
    end

    assign pc_o = pc_q;

    always_comb begin
        pc_d = pred_pc_o;
        if (i_redirect) begin
            pc_d = i_redirect_pc;
        end else if (i_stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign uidx = i_upd_pc[INDEX_W+1:2];
    assign utag = i_upd_pc[31:INDEX_W+2];
    assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

    // A not-taken miss leaves the table alone; a taken miss evicts whatever lived at uidx.
    always_comb begin
        upd_we   = 1'b0;
        bht_wr_d = bht_q[uidx];
        tgt_wr_d = tgt_q[uidx];
        if (i_upd_vld) begin
            if (uhit) begin
                upd_we = 1'b1;
                if (i_upd_taken) begin
                    tgt_wr_d = i_upd_target;
                    if (bht_q[uidx] != 2'b11) begin
                        bht_wr_d = bht_q[uidx] + 2'b01;
                    end
                end else if (bht_q[uidx] != 2'b00) begin
                    bht_wr_d = bht_q[uidx] - 2'b01;
                end
            end else if (i_upd_taken) begin
                upd_we   = 1'b1;
                bht_wr_d = 2'b10;
                tgt_wr_d = i_upd_target;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (upd_we) begin
            valid_q[uidx] <= 1'b1;
            bht_q[uidx]   <= bht_wr_d;
        end
    end

    // Tag and target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge i_clk) begin
        if (upd_we) begin
            tag_q[uidx] <= utag;
            tgt_q[uidx] <= tgt_wr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] br_cnt_d;
    logic [31:0] mispred_cnt_q;
    logic [31:0] mispred_cnt_d;

    always_comb begin
        br_cnt_d      = br_cnt_q + {31'd0, i_upd_vld};
        mispred_cnt_d = mispred_cnt_q + {31'd0, i_redirect};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`endif

endmodule
